piso_shift_reg: RTL and testbench

//   Parallel-in serial-out shift register. Captures a BITS-wide word on a load

---
 rtl/piso_pkg.sv | 11 +
 rtl/piso_bit_counter.sv | 33 +++
 rtl/piso_shift_reg.sv | 46 ++++
 tb/tb_piso_shift_reg.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared constants and helpers for the parallel-in serial-out shifter.
package piso_pkg;

    localparam int unsigned PISO_BITS_DEF = 8;

    // Width needed to hold a bit count from 0 up to and including bits.
    function automatic int unsigned cnt_w(input int unsigned bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Down-counter reporting how many serial bits of the current word remain.
// Present only when PISO_STATUS_EN is defined.
`ifdef PISO_STATUS_EN
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int unsigned BITS = PISO_BITS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    output logic                      busy,
    output logic [cnt_w(BITS)-1:0]    bits_left
);

    localparam int unsigned CW = cnt_w(BITS);

    // Load arms a full word; each shift edge consumes one bit, saturating at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bits_left <= '0;
            busy      <= 1'b0;
        end else if (load) begin
            bits_left <= CW'(BITS);
            busy      <= 1'b1;
        end else if (bits_left != '0) begin
            bits_left <= bits_left - CW'(1);
            busy      <= (bits_left > CW'(1));
        end
    end

endmodule
`endif

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, MSB first, zero fill after the word.
// Define PISO_STATUS_EN to add busy/bits_left status outputs.
module piso_shift_reg
    import piso_pkg::*;
#(
    parameter int unsigned BITS = PISO_BITS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [BITS-1:0]           d_in,
`ifdef PISO_STATUS_EN
    output logic                      busy,
    output logic [cnt_w(BITS)-1:0]    bits_left,
`endif
    output logic                      s_out
);

    logic [BITS-1:0] shift_reg;

    // Load overrides shifting, so a mid-word load discards the remaining bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
        end else if (load) begin
            shift_reg <= d_in;
        end else begin
            shift_reg <= {shift_reg[BITS-2:0], 1'b0};
        end
    end

    assign s_out = shift_reg[BITS-1];

`ifdef PISO_STATUS_EN
    piso_bit_counter #(
        .BITS      (BITS)
    ) u_bit_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .busy      (busy),
        .bits_left (bits_left)
    );
`endif

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench for piso_shift_reg against a queue-of-pending-bits model.
module tb_piso_shift_reg;

    localparam int unsigned BITS = 8;

    logic             clk;
    logic             rst;
    logic             load;
    logic [BITS-1:0]  d_in;
    logic             s_out;
`ifdef PISO_STATUS_EN
    logic             busy;
    logic [$clog2(BITS+1)-1:0] bits_left;
`endif

    int checks = 0;
    int errors = 0;

    // Bits still to be emitted, front = currently presented bit.
    logic pend[$];

    piso_shift_reg #(
        .BITS      (BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .d_in      (d_in),
`ifdef PISO_STATUS_EN
        .busy      (busy),
        .bits_left (bits_left),
`endif
        .s_out     (s_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic ld, input logic [BITS-1:0] d);
        if (!rst) begin
            pend.delete();
        end else if (ld) begin
            pend.delete();
            for (int i = BITS - 1; i >= 0; i--) pend.push_back(d[i]);
        end else if (pend.size() > 0) begin
            void'(pend.pop_front());
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_bit;
        exp_bit = (pend.size() > 0) ? pend[0] : 1'b0;
        chk(tag, {7'd0, s_out}, {7'd0, exp_bit});
`ifdef PISO_STATUS_EN
        chk({tag, "_bits_left"}, 8'(bits_left), 8'(pend.size()));
        chk({tag, "_busy"}, {7'd0, busy}, {7'd0, pend.size() != 0});
`endif
    endtask

    task automatic step(input string tag, input logic ld, input logic [BITS-1:0] d);
        load = ld;
        d_in = d;
        @(posedge clk);
        model_edge(ld, d);
        #1;
        check_all(tag);
    endtask

    // Assert reset between edges, check immediately, hold through one edge, release mid-cycle.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        pend.delete();
        check_all({tag, "_async"});
        step({tag, "_held"}, 1'b0, BITS'($urandom));
        #2;
        rst = 1'b1;
    endtask

    initial begin
        logic [BITS-1:0] w;
        logic [7:0] exp2 [0:8];
        exp2 = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1, 8'd0};

        rst  = 1'b0;
        load = 1'b1;
        d_in = 8'hFF;
        #1;
        check_all("reset_initial");

        // 1: reset dominates load, release with load low leaves register clear
        step("reset_load0", 1'b1, 8'hFF);
        step("reset_load1", 1'b1, 8'hFF);
        #2;
        rst = 1'b1;
        step("reset_release", 1'b0, 8'hFF);

        // 2: full word 8'b11001011 then trailing zeros
        step("t2_load", 1'b1, 8'b11001011);
        chk("t2_const0", {7'd0, s_out}, exp2[0]);
        for (int i = 1; i <= 8; i++) begin
            step("t2_shift", 1'b0, BITS'($urandom));
            chk("t2_const", {7'd0, s_out}, exp2[i]);
        end
        step("t2_idle", 1'b0, 8'hFF);

        // 3: mid-word reload
        step("t3_load_a5", 1'b1, 8'hA5);
        for (int i = 0; i < 3; i++) step("t3_shift_a5", 1'b0, 8'h00);
        step("t3_load_3c", 1'b1, 8'h3C);
        chk("t3_jump", {7'd0, s_out}, 8'd0);
        for (int i = 0; i < 8; i++) step("t3_shift_3c", 1'b0, 8'hFF);

        // 4: load held high keeps presenting the MSB
        for (int i = 0; i < 4; i++) begin
            step("t4_hold", 1'b1, 8'h80);
            chk("t4_hold_const", {7'd0, s_out}, 8'd1);
        end
        step("t4_release", 1'b0, 8'h80);
        chk("t4_release_const", {7'd0, s_out}, 8'd0);

        // 5: async reset mid-shift, no residual bits afterwards
        step("t5_load", 1'b1, 8'hFF);
        step("t5_shift", 1'b0, 8'h00);
        async_reset("t5");
        for (int i = 0; i < 4; i++) step("t5_after", 1'b0, 8'hFF);

`ifdef PISO_STATUS_EN
        // 6: status counter walk
        step("t6_load", 1'b1, 8'hCB);
        chk("t6_bits_left_const", 8'(bits_left), 8'd8);
        for (int i = 7; i >= 0; i--) begin
            step("t6_shift", 1'b0, 8'h00);
            chk("t6_bits_left_walk", 8'(bits_left), 8'(i));
        end
        chk("t6_busy_done", {7'd0, busy}, 8'd0);
`endif

        // Randomized traffic with occasional async resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset("rnd");
            end else begin
                w = BITS'($urandom);
                step("rnd", ($urandom_range(0, 5) == 0), w);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1);
    end

endmodule
